// File: rtl/reset_sequencer_if.sv
// Signal bundle between the board-level reset inputs and the CPU reset sequencer.
interface reset_sequencer_if;
    logic       button_in;
    logic       pll_lock;
    logic       ctrl_lock;
    logic       cpu_rst;
    logic       ready;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    modport master (
        output button_in, pll_lock, ctrl_lock,
        input  cpu_rst, ready, rst_cause, rst_count
    );

    modport slave (
        input  button_in, pll_lock, ctrl_lock,
        output cpu_rst, ready, rst_cause, rst_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// CPU reset generator: synchronises and debounces the button, waits for PLL and
// IDELAYCTRL lock, then holds cpu_rst for a fixed count; reports cause and count.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned CNT_W           = 16
) (
    input logic               clk,
    input logic               rst_n,
    reset_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StLockWait, StHold, StRun} state_e;

    logic [SYNC_STAGES-1:0] btn_sync, pll_sync, ctrl_sync;
    logic                   btn_s, locks_ok;
    logic                   deb_q;
    logic [CNT_W-1:0]       deb_cnt;
    logic                   deb_flip, press;

    state_e           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             cpu_rst_q, ready_q;
    logic [1:0]       cause_q;
    logic [7:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync  <= '0;
            pll_sync  <= '0;
            ctrl_sync <= '0;
        end else begin
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], bus.button_in};
            pll_sync  <= {pll_sync[SYNC_STAGES-2:0], bus.pll_lock};
            ctrl_sync <= {ctrl_sync[SYNC_STAGES-2:0], bus.ctrl_lock};
        end
    end

    assign btn_s    = btn_sync[SYNC_STAGES-1];
    assign locks_ok = pll_sync[SYNC_STAGES-1] & ctrl_sync[SYNC_STAGES-1];

    // Press fires on the same edge the debounced level rises, so the FSM reacts in step.
    assign deb_flip = (btn_s != deb_q) && (deb_cnt == DEB_MAX);
    assign press    = deb_flip && btn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == deb_q) begin
            deb_cnt <= '0;
        end else if (deb_flip) begin
            deb_q   <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StLockWait;
            hold_cnt  <= '0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            cause_q   <= 2'd0;
            count_q   <= 8'd0;
        end else begin
            unique case (state)
                StLockWait: begin
                    if (locks_ok) begin
                        state    <= StHold;
                        hold_cnt <= '0;
                    end
                end
                StHold: begin
                    if (!locks_ok) begin
                        state <= StLockWait;
                    end else if (press || deb_q) begin
                        // Reset stretches for as long as the button stays down.
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_MAX) begin
                        state     <= StRun;
                        cpu_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (!locks_ok) begin
                        state     <= StLockWait;
                        cpu_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        cause_q   <= 2'd1;
                    end else if (press) begin
                        state     <= StHold;
                        hold_cnt  <= '0;
                        cpu_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        cause_q   <= 2'd2;
                    end
                end
                default: begin
                    state     <= StLockWait;
                    cpu_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.ready     = ready_q;
    assign bus.rst_cause = cause_q;
    assign bus.rst_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: vector table for run/press/lock-loss phases,
// hand sequences for exact latencies, async reset and count saturation.
module tb_reset_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (16),
        .CNT_W           (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        button;
        logic        pll;
        logic        ctrl;
        int unsigned cycles;
        bit          each;
        logic        exp_rst;
        logic        exp_ready;
        logic [1:0]  exp_cause;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic b, input logic p, input logic c,
                                input int unsigned n, input bit e, input logic r,
                                input logic rdy, input logic [1:0] cs, input logic [7:0] cn);
        vec_t v;
        v.button = b; v.pll = p; v.ctrl = c; v.cycles = n; v.each = e;
        v.exp_rst = r; v.exp_ready = rdy; v.exp_cause = cs; v.exp_count = cn;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] got,
                         input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string name, input int idx, input logic r,
                             input logic rdy, input logic [1:0] cs, input logic [7:0] cn);
        check({name, ".cpu_rst"},   idx, {7'd0, bus.cpu_rst}, {7'd0, r});
        check({name, ".ready"},     idx, {7'd0, bus.ready},   {7'd0, rdy});
        check({name, ".rst_cause"}, idx, {6'd0, bus.rst_cause}, {6'd0, cs});
        check({name, ".rst_count"}, idx, bus.rst_count, cn);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.button_in = 1'b0;
        bus.pll_lock  = 1'b1;
        bus.ctrl_lock = 1'b1;

        // Power-up
        step(5);
        check_all("reset", 0, 1'b1, 1'b0, 2'd0, 8'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            if (k == 18) check("powerup_hold", k, {7'd0, bus.cpu_rst}, 8'd1);
            if (k == 19) check_all("powerup_run", k, 1'b0, 1'b1, 2'd0, 8'd1);
        end

        // Bounce: 3-cycle toggles never satisfy an 8-cycle debounce
        for (int i = 0; i < 14; i++) add(~i[0], 1, 1, 3, 1, 0, 1, 2'd0, 8'd1);
        add(0, 1, 1, 3, 0, 0, 1, 2'd0, 8'd1);
        // Clean press: 2 sync + 8 debounce edges
        add(1, 1, 1, 9, 1, 0, 1, 2'd0, 8'd1);
        add(1, 1, 1, 1, 0, 1, 0, 2'd2, 8'd1);
        // Held button keeps reset asserted; release debounces in 10 then holds 16
        add(1, 1, 1, 90, 1, 1, 0, 2'd2, 8'd1);
        add(0, 1, 1, 25, 1, 1, 0, 2'd2, 8'd1);
        add(0, 1, 1, 1, 0, 0, 1, 2'd2, 8'd2);
        // One-cycle ctrl_lock drop
        add(0, 1, 0, 1, 0, 0, 1, 2'd2, 8'd2);
        add(0, 1, 1, 1, 0, 0, 1, 2'd2, 8'd2);
        add(0, 1, 1, 1, 0, 1, 0, 2'd1, 8'd2);
        add(0, 1, 1, 16, 1, 1, 0, 2'd1, 8'd2);
        add(0, 1, 1, 1, 0, 0, 1, 2'd1, 8'd3);

        foreach (tbl[i]) begin
            bus.button_in = tbl[i].button;
            bus.pll_lock  = tbl[i].pll;
            bus.ctrl_lock = tbl[i].ctrl;
            for (int c = 0; c < int'(tbl[i].cycles); c++) begin
                @(posedge clk);
                #1;
                if (tbl[i].each)
                    check("row_each_cpu_rst", i, {7'd0, bus.cpu_rst}, {7'd0, tbl[i].exp_rst});
            end
            check_all("row", i, tbl[i].exp_rst, tbl[i].exp_ready, tbl[i].exp_cause,
                      tbl[i].exp_count);
        end

        // Press and pll drop land on the same synced edge: lock loss wins
        bus.button_in = 1'b1;
        step(7);
        bus.pll_lock = 1'b0;
        step(2);
        check("simul_before", 0, {7'd0, bus.cpu_rst}, 8'd0);
        step(1);
        check_all("simul", 0, 1'b1, 1'b0, 2'd1, 8'd3);

        // Lock loss mid-HOLD returns to LOCKWAIT without counting a reset
        bus.button_in = 1'b0;
        bus.pll_lock  = 1'b1;
        step(15);
        bus.pll_lock = 1'b0;
        step(3);
        check_all("midhold_loss", 0, 1'b1, 1'b0, 2'd1, 8'd3);
        bus.pll_lock = 1'b1;
        step(18);
        check("relock_hold", 0, {7'd0, bus.cpu_rst}, 8'd1);
        step(1);
        check_all("relock_run", 0, 1'b0, 1'b1, 2'd1, 8'd4);

        // Asynchronous reset in the middle of HOLD
        bus.button_in = 1'b1;
        step(10);
        check_all("pre_async", 0, 1'b1, 1'b0, 2'd2, 8'd4);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 1'b1, 1'b0, 2'd0, 8'd0);
        bus.button_in = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(18);
        check("rerun_hold", 0, {7'd0, bus.cpu_rst}, 8'd1);
        step(1);
        check_all("rerun", 0, 1'b0, 1'b1, 2'd0, 8'd1);

        // Saturation: 300 button resets
        for (int i = 0; i < 300; i++) begin
            bus.button_in = 1'b1;
            step(12);
            bus.button_in = 1'b0;
            step(30);
            if (i == 100) check_all("sat_mid", i, 1'b0, 1'b1, 2'd2, 8'd102);
        end
        check_all("saturate", 0, 1'b0, 1'b1, 2'd2, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
